// File: rtl/hamming_decoder.sv
// Hamming SECDED (16,11) block decoder.
// Walks NUM_MSG codewords in data memory, corrects single-bit errors, flags
// double-bit errors and writes each decoded message back as two bytes.
module hamming_decoder #(
    parameter int NUM_MSG  = 15,
    parameter int IN_BASE  = 30,
    parameter int OUT_BASE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] mem_wr_data,
    output logic       mem_wr_en
);

    // The message index is at least 4 bits wide, wider only for very long runs.
    localparam int IDX_W = (NUM_MSG > 16) ? $clog2(NUM_MSG) : 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_LO  = 3'd1;
    localparam logic [2:0] S_RD_HI  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_WR_LO  = 3'd4;
    localparam logic [2:0] S_WR_HI  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      cw_q, cw_d;
    logic [15:0]      res_q, res_d;
    logic [15:0]      dec_result;
    logic [7:0]       in_addr;
    logic [7:0]       out_addr;

    // Syndrome/parity classification and data extraction for one codeword.
    // Result layout: {flags[1:0], 3'b000, d11..d1}.
    function automatic logic [15:0] decode_word(input logic [15:0] cw);
        logic [3:0]  syn;
        logic        par;
        logic [15:0] fixed;
        logic [1:0]  flags;
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        par   = ^cw;
        fixed = cw;
        // A nonzero syndrome with odd parity points at the single flipped bit.
        if (syn != 4'd0 && par) fixed[syn] = ~cw[syn];
        if (par)               flags = 2'b01;
        else if (syn != 4'd0)  flags = 2'b10;
        else                   flags = 2'b00;
        return {flags, 3'b000, fixed[15:9], fixed[7:5], fixed[3]};
    endfunction

    assign dec_result = decode_word(cw_q);
    assign in_addr    = 8'(IN_BASE)  + 8'({idx_q, 1'b0});
    assign out_addr   = 8'(OUT_BASE) + 8'({idx_q, 1'b0});

    // Next-state, index, codeword latch and result register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cw_d    = cw_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RD_LO;
                    idx_d   = '0;
                end
            end
            S_RD_LO: begin
                cw_d    = {cw_q[15:8], mem_rd_data};
                state_d = S_RD_HI;
            end
            S_RD_HI: begin
                cw_d    = {mem_rd_data, cw_q[7:0]};
                state_d = S_DECODE;
            end
            S_DECODE: begin
                res_d   = dec_result;
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_RD_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs decoded from the current state; IDLE drives all zeros.
    always_comb begin
        mem_addr    = 8'd0;
        mem_wr_data = 8'd0;
        mem_wr_en   = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_RD_LO: mem_addr = in_addr;
            S_RD_HI: mem_addr = in_addr + 8'd1;
            S_WR_LO: begin
                mem_addr    = out_addr;
                mem_wr_data = res_q[7:0];
                mem_wr_en   = 1'b1;
            end
            S_WR_HI: begin
                mem_addr    = out_addr + 8'd1;
                mem_wr_data = res_q[15:8];
                mem_wr_en   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // State registers; reset takes effect immediately and abandons any run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cw_q    <= 16'd0;
            res_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cw_q    <= cw_d;
            res_q   <= res_d;
        end
    end

endmodule
